// File: rtl/beacon_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : beacon_spi_pkg
//  Purpose   : Shared constants and helpers for the beacon SPI frame packer.
//  Revision  : 1.0  initial release
// ============================================================================
package beacon_spi_pkg;

  // First byte of every frame, lets the master resynchronise on a byte stream
  localparam logic [7:0] FRAME_HEADER = 8'hA5;

  // Bit of the status byte set on the first frame after a snapshot swap
  localparam int STATUS_FRESH_BIT = 7;

  // Header + status + four coordinate bytes per beacon + checksum
  function automatic int frame_len(input int n);
    return 3 + 4 * n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module    : sync_edge_detect
//  Purpose   : Two-flop synchroniser for an asynchronous level, plus a
//              one-cycle pulse on its synchronised rising edge.
//  Revision  : 1.0  initial release
// ============================================================================
module sync_edge_detect #(
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Shift the raw input through the synchroniser and keep one delayed copy
  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Reset to the idle level so no spurious edge appears when reset releases
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= RESET_LEVEL;
      sync_q <= RESET_LEVEL;
      prev_q <= RESET_LEVEL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_pulse = sync_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/beacon_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module    : beacon_frame_packer
//  Purpose   : Packs double-buffered beacon detections into a checksummed
//              byte frame and feeds it, one byte per SPI byte, to the slave.
//  Revision  : 1.0  initial release
// ============================================================================
module beacon_frame_packer
  import beacon_spi_pkg::*;
#(
  parameter int NUM_BEACONS = 3,
  parameter int COORD_W     = 11
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           beacon_valid,
  input  logic [NUM_BEACONS-1:0]         beacon_mask,
  input  logic [NUM_BEACONS*COORD_W-1:0] beacon_xmin,
  input  logic [NUM_BEACONS*COORD_W-1:0] beacon_xmax,
  input  logic                           spi_sent,
  input  logic                           spi_ss_n,
  output logic [7:0]                     byte_out,
  output logic                           frame_done,
  output logic                           overrun
);

  localparam int               FRAME_LEN = frame_len(NUM_BEACONS);
  localparam int               IDX_W     = $clog2(FRAME_LEN);
  localparam int               XW        = NUM_BEACONS * COORD_W;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);

  logic                   sent_q, sent_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [7:0]             chk_q, chk_d;
  logic [7:0]             byte_out_q, byte_d;
  logic                   frame_done_q, frame_done_d;
  logic                   overrun_q, overrun_d;
  logic                   fresh_q, fresh_d;
  logic                   pending_flag_q, pending_flag_d;
  logic [NUM_BEACONS-1:0] pending_mask_q, pending_mask_d;
  logic [XW-1:0]          pending_xmin_q, pending_xmin_d;
  logic [XW-1:0]          pending_xmax_q, pending_xmax_d;
  logic [NUM_BEACONS-1:0] active_mask_q, active_mask_d;
  logic [XW-1:0]          active_xmin_q, active_xmin_d;
  logic [XW-1:0]          active_xmax_q, active_xmax_d;

  logic       ss_rise_w;
  logic       adv_w;
  logic       at_last_w;
  logic       wrap_w;
  logic [7:0] status_w;
  logic [15:0] xmin16_w;
  logic [15:0] xmax16_w;

  // SS is asynchronous to clk; its rising edge means the master aborted/ended
  sync_edge_detect #(
    .RESET_LEVEL (1'b1)
  ) u_ss_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .async_in   (spi_ss_n),
    .rise_pulse (ss_rise_w)
  );

  // Frame sequencing, snapshot double-buffering and running checksum
  always_comb begin
    sent_d         = spi_sent;
    idx_d          = idx_q;
    chk_d          = chk_q;
    fresh_d        = fresh_q;
    pending_flag_d = pending_flag_q;
    pending_mask_d = pending_mask_q;
    pending_xmin_d = pending_xmin_q;
    pending_xmax_d = pending_xmax_q;
    active_mask_d  = active_mask_q;
    active_xmin_d  = active_xmin_q;
    active_xmax_d  = active_xmax_q;

    adv_w     = spi_sent & ~sent_q;
    at_last_w = (idx_q == LAST_IDX);
    wrap_w    = adv_w & ~ss_rise_w & at_last_w;

    if (ss_rise_w) begin
      // Transaction ended mid-frame: restart the same snapshot from the header
      idx_d = '0;
      chk_d = '0;
    end else if (adv_w) begin
      if (at_last_w) begin
        idx_d = '0;
        chk_d = '0;
        if (pending_flag_q) begin
          active_mask_d  = pending_mask_q;
          active_xmin_d  = pending_xmin_q;
          active_xmax_d  = pending_xmax_q;
          fresh_d        = 1'b1;
          pending_flag_d = 1'b0;
        end else begin
          fresh_d = 1'b0;
        end
      end else begin
        idx_d = idx_q + IDX_W'(1);
        // byte_out_q is the byte just consumed by the slave
        chk_d = chk_q ^ byte_out_q;
      end
    end

    // New data lands after any swap, so a coincident wrap promotes the old pending
    overrun_d = beacon_valid & pending_flag_q & ~wrap_w;
    if (beacon_valid) begin
      pending_mask_d = beacon_mask;
      pending_xmin_d = beacon_xmin;
      pending_xmax_d = beacon_xmax;
      pending_flag_d = 1'b1;
    end

    frame_done_d = wrap_w;
  end

  // Byte for the index being entered, so byte_out is valid right after an advance
  always_comb begin
    status_w                        = 8'h00;
    status_w[STATUS_FRESH_BIT]      = fresh_d;
    status_w[NUM_BEACONS-1:0]       = active_mask_d;
    xmin16_w                        = '0;
    xmax16_w                        = '0;
    byte_d                          = FRAME_HEADER;
    if (idx_d == IDX_W'(1)) begin
      byte_d = status_w;
    end
    if (idx_d == LAST_IDX) begin
      byte_d = chk_d;
    end
    for (int i = 0; i < NUM_BEACONS; i++) begin
      xmin16_w = 16'(active_xmin_d[i*COORD_W +: COORD_W]);
      xmax16_w = 16'(active_xmax_d[i*COORD_W +: COORD_W]);
      if (idx_d == IDX_W'(2 + 4*i)) byte_d = xmin16_w[15:8];
      if (idx_d == IDX_W'(3 + 4*i)) byte_d = xmin16_w[7:0];
      if (idx_d == IDX_W'(4 + 4*i)) byte_d = xmax16_w[15:8];
      if (idx_d == IDX_W'(5 + 4*i)) byte_d = xmax16_w[7:0];
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sent_q         <= 1'b0;
      idx_q          <= '0;
      chk_q          <= '0;
      byte_out_q     <= FRAME_HEADER;
      frame_done_q   <= 1'b0;
      overrun_q      <= 1'b0;
      fresh_q        <= 1'b0;
      pending_flag_q <= 1'b0;
      pending_mask_q <= '0;
      pending_xmin_q <= '0;
      pending_xmax_q <= '0;
      active_mask_q  <= '0;
      active_xmin_q  <= '0;
      active_xmax_q  <= '0;
    end else begin
      sent_q         <= sent_d;
      idx_q          <= idx_d;
      chk_q          <= chk_d;
      byte_out_q     <= byte_d;
      frame_done_q   <= frame_done_d;
      overrun_q      <= overrun_d;
      fresh_q        <= fresh_d;
      pending_flag_q <= pending_flag_d;
      pending_mask_q <= pending_mask_d;
      pending_xmin_q <= pending_xmin_d;
      pending_xmax_q <= pending_xmax_d;
      active_mask_q  <= active_mask_d;
      active_xmin_q  <= active_xmin_d;
      active_xmax_q  <= active_xmax_d;
    end
  end

  assign byte_out   = byte_out_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire
